// File: rtl/shared_main_memory_if.sv
// Request/ack bus between bus_arbitrator (master) and shared_main_memory (slave).
// Handshake: master raises mem_req with mem_we/mem_addr/mem_wdata and holds
// mem_req high until it sees the one-cycle mem_ack pulse, then drops it for at
// least one cycle. The slave samples the request only in IDLE, ignores request
// fields after acceptance, and reports mem_busy whenever it is not in IDLE.
interface shared_main_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_busy;
  logic              init_done;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack, mem_busy, init_done
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack, mem_busy, init_done
  );
endinterface

// File: rtl/shared_main_memory.sv
// Single-ported 2**ADDR_W x DATA_W main memory with a post-reset init sweep and
// a fixed-latency req/ack handshake toward the bus arbitrator.
module shared_main_memory #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  shared_main_memory_if.slave  bus,
  output logic [2:0]           dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_ACCESS    = 3'd2,
    S_RESP      = 3'd3,
    S_WAIT_DROP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              init_done_q, init_done_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    init_done_d = init_done_q;
    mem_wr_en   = 1'b0;
    mem_wr_addr = ptr_q;
    mem_wr_data = DATA_W'(ptr_q);

    case (state_q)
      S_INIT: begin
        mem_wr_en = 1'b1;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.mem_req) begin
          addr_d  = bus.mem_addr;
          we_d    = bus.mem_we;
          wdata_d = bus.mem_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          if (we_q) begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = addr_q;
            mem_wr_data = wdata_q;
          end else begin
            rdata_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        // A request still held after ack must not be serviced a second time.
        if (!bus.mem_req) state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT;
      ptr_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  // Reset blocks the write so an aborted transaction never commits.
  always_ff @(posedge clk) begin
    if (rst && mem_wr_en) mem_q[mem_wr_addr] <= mem_wr_data;
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ack   = (state_q == S_RESP);
  assign bus.mem_busy  = (state_q != S_IDLE);
  assign bus.init_done = init_done_q;
  assign dbg_state_o   = state_q;

endmodule
